// File: rtl/sdpram_be.sv
// Simple dual-port RAM with one write port and one read port on a shared clock.
// Writes use per-byte enables. Reads take 1 or 2 cycles and raise rd_valid for one cycle.
// When a read and a write hit the same address in the same cycle, WRITE_FIRST picks
// whether the read returns the old word or the byte-merged new word.
module sdpram_be #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 2,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_FIRST  = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_din,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_dout,
  output logic                    rd_valid
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;

  // Flattened view of all memory words, used by the read mux.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_words;

  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [DATA_WIDTH-1:0] rd_dout_reg;
  logic                  rd_valid_reg;

  // Each memory word is a separate register.
  // The word's next value merges the enabled write bytes into the current contents.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [DATA_WIDTH-1:0] word_reg;
    logic [DATA_WIDTH-1:0] word_next;

    // Byte-merge the write data into this word when it is the write target.
    always_comb begin
      word_next = word_reg;
      if (wr_en && (wr_addr == ADDR_WIDTH'(gi))) begin
        for (int b = 0; b < NBYTES; b++) begin
          if (wr_be[b]) word_next[8*b +: 8] = wr_din[8*b +: 8];
        end
      end
    end

    // Word storage; the asynchronous reset clears the contents.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) word_reg <= '0;
      else         word_reg <= word_next;
    end

    assign mem_words[gi] = word_reg;
  end

  assign rd_old = mem_words[rd_addr];

  // Read data as sampled at the request edge.
  // In write-first mode, a same-address write forwards its enabled bytes.
  always_comb begin
    rd_data = rd_old;
    if ((WRITE_FIRST != 0) && wr_en && (wr_addr == rd_addr)) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) rd_data[8*b +: 8] = wr_din[8*b +: 8];
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_lat1
    // Single-stage read: capture on request; rd_dout holds when there is no request.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_dout_reg  <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        rd_valid_reg <= rd_en;
        if (rd_en) rd_dout_reg <= rd_data;
      end
    end
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_data_reg;
    logic                  s1_valid_reg;

    // Stage 1 captures data at the request edge.
    // Later writes therefore cannot disturb a read that is already in flight.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1_data_reg  <= '0;
        s1_valid_reg <= 1'b0;
      end else begin
        s1_valid_reg <= rd_en;
        if (rd_en) s1_data_reg <= rd_data;
      end
    end

    // Stage 2 drives the outputs and updates rd_dout only for a valid stage-1 entry.
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        rd_dout_reg  <= '0;
        rd_valid_reg <= 1'b0;
      end else begin
        rd_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) rd_dout_reg <= s1_data_reg;
      end
    end
  end else begin : g_bad_latency
    $error("sdpram_be: READ_LATENCY must be 1 or 2");
  end

  assign rd_dout  = rd_dout_reg;
  assign rd_valid = rd_valid_reg;

endmodule

// File: tb/tb_sdpram_be.sv
// Scoreboard bench for sdpram_be with two instances driven by identical stimulus.
// Instance a uses 1-cycle latency with read-first collisions.
// Instance b uses 2-cycle latency with write-first collisions.
module tb_sdpram_be;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int NB = DW / 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_din;
  logic [NB-1:0] wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] dout_a, dout_b;
  logic          valid_a, valid_b;

  always #5 clk = ~clk;

  sdpram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1), .WRITE_FIRST(0)) u_dut_a (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout_a), .rd_valid(valid_a)
  );

  sdpram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2), .WRITE_FIRST(1)) u_dut_b (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr), .wr_din(wr_din),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(dout_b), .rd_valid(valid_b)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q_a[$];
  exp_t          q_b[$];
  logic [DW-1:0] model_mem[4];
  logic [DW-1:0] last_a, last_b;
  int            edge_n = 0;
  int            n_vec  = 0;
  int            n_err  = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic check_outputs();
    if (q_a.size() > 0 && q_a[0].due == edge_n) begin
      check("a_valid", {31'd0, valid_a}, 32'd1);
      check("a_dout", dout_a, q_a[0].data);
      $display("edge %0d dut_a read done data=%h", edge_n, dout_a);
      last_a = q_a[0].data;
      q_a.delete(0);
    end else begin
      check("a_valid_idle", {31'd0, valid_a}, 32'd0);
      check("a_hold", dout_a, last_a);
    end
    if (q_b.size() > 0 && q_b[0].due == edge_n) begin
      check("b_valid", {31'd0, valid_b}, 32'd1);
      check("b_dout", dout_b, q_b[0].data);
      $display("edge %0d dut_b read done data=%h", edge_n, dout_b);
      last_b = q_b[0].data;
      q_b.delete(0);
    end else begin
      check("b_valid_idle", {31'd0, valid_b}, 32'd0);
      check("b_hold", dout_b, last_b);
    end
  endtask

  // One clock cycle: drive inputs, update the model, clock, then check at the falling edge.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input logic re, input logic [AW-1:0] ra);
    logic [DW-1:0] old_w, merged;
    exp_t          ea, eb;
    wr_en = we; wr_addr = wa; wr_din = wd; wr_be = be;
    rd_en = re; rd_addr = ra;
    if (resetn) begin
      if (re) begin
        old_w  = model_mem[ra];
        merged = old_w;
        if (we && wa == ra)
          for (int b = 0; b < NB; b++) if (be[b]) merged[8*b +: 8] = wd[8*b +: 8];
        ea.due = edge_n + 1; ea.data = old_w;
        eb.due = edge_n + 2; eb.data = merged;
        q_a.push_back(ea);
        q_b.push_back(eb);
      end
      if (we)
        for (int b = 0; b < NB; b++) if (be[b]) model_mem[wa][8*b +: 8] = wd[8*b +: 8];
    end
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_mem[i] = '0;
    q_a.delete();
    q_b.delete();
    last_a = '0;
    last_b = '0;
  endtask

  initial begin
    resetn = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_din = '0; wr_be = '0;
    rd_en = 1'b0; rd_addr = '0;
    clear_model();
    @(negedge clk);
    idle();
    idle();
    resetn = 1'b1;

    // Reads from a freshly reset memory.
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i));
    idle();
    idle();

    // Byte enables.
    step(1'b1, 2'd1, 32'hAABBCCDD, 4'hF, 1'b0, '0);
    step(1'b1, 2'd1, 32'h11223344, 4'b0101, 1'b0, '0);
    step(1'b1, 2'd1, 32'hDEADBEEF, 4'b0000, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 2'd1);
    check("be_merge_a", dout_a, 32'hAA22CC44);
    idle();
    check("be_merge_b", dout_b, 32'hAA22CC44);

    // Same-address collision.
    step(1'b1, 2'd2, 32'h12345678, 4'hF, 1'b0, '0);
    step(1'b1, 2'd2, 32'hFFFFFFFF, 4'b0011, 1'b1, 2'd2);
    check("coll_a_old", dout_a, 32'h12345678);
    step(1'b0, '0, '0, '0, 1'b1, 2'd2);
    check("coll_b_new", dout_b, 32'h1234FFFF);
    check("coll_a_after", dout_a, 32'h1234FFFF);
    idle();
    check("coll_b_after", dout_b, 32'h1234FFFF);

    // Back-to-back streaming reads.
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 32'h10 * (i + 1), 4'hF, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i));
    for (int i = 0; i < 3; i++) idle();
    check("stream_hold_b", dout_b, 32'h40);

    // Idle hold while other addresses are written.
    step(1'b1, 2'd0, 32'h55, 4'hF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 2'd0);
    for (int i = 0; i < 5; i++) step(1'b1, AW'(1 + (i % 3)), $urandom, 4'hF, 1'b0, '0);
    check("idle_hold_b", dout_b, 32'h55);

    // Random mixed traffic, including collisions and empty byte masks.
    for (int i = 0; i < 40; i++)
      step(1'(($urandom_range(0, 3)) != 0), AW'($urandom_range(0, 3)), $urandom,
           NB'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)));
    for (int i = 0; i < 3; i++) idle();

    // Reset between the request edge and the output edge of a 2-cycle read.
    step(1'b1, 2'd3, 32'hCAFEF00D, 4'hF, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 2'd3);
    resetn = 1'b0;
    #1;
    check("midrst_valid_b", {31'd0, valid_b}, 32'd0);
    check("midrst_dout_b", dout_b, 32'd0);
    check("midrst_dout_a", dout_a, 32'd0);
    clear_model();
    @(negedge clk);
    idle();
    idle();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, '0, 1'b1, AW'(i));
    for (int i = 0; i < 3; i++) idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
